// File: rtl/joltage.sv
// Streaming battery-bank evaluator: per captured line, finds the largest 2-digit and
// 12-digit in-order subsequences and accumulates both into running sums.
module joltage #(
    parameter int LENGTH = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data_valid,
    input  logic [3:0]  line [0:LENGTH-1],
    output logic [15:0] joltage1_out,
    output logic [63:0] joltage2_out,
    output logic        done
);

    localparam int IW = $clog2(LENGTH + 1);
    localparam int K1 = 2;
    localparam int K2 = 12;

    typedef enum logic [1:0] {IDLE, SCAN, ACC, DONE} state_t;

    state_t        state;
    logic [3:0]    digits [0:LENGTH-1];
    logic [IW-1:0] idx;

    logic [3:0]    sel1 [0:K1-1];
    logic [1:0]    cnt1;
    logic [3:0]    sel2 [0:K2-1];
    logic [3:0]    cnt2;

    logic [3:0]    sel1_nxt [0:K1-1];
    logic [1:0]    cnt1_nxt;
    logic [3:0]    sel2_nxt [0:K2-1];
    logic [3:0]    cnt2_nxt;
    logic [15:0]   part1;
    logic [39:0]   part2;

    // Digits are shifted toward index 0, so the digit under scan is always digits[0].
    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        int rem;
        int p1;
        int p2;
        int j1;
        int j2;

        sel1_nxt = sel1;
        cnt1_nxt = cnt1;
        sel2_nxt = sel2;
        cnt2_nxt = cnt2;
        rem      = LENGTH - int'(idx);

        // Pop every kept digit smaller than d, but never below the slot that
        // still leaves room for the digits remaining in the line.
        p1 = 0;
        for (int i = 0; i < K1; i++)
            if (i < int'(cnt1) && sel1[i] >= digits[0]) p1 = i + 1;
        j1 = (K1 - rem > p1) ? K1 - rem : p1;
        if (j1 < K1) begin
            for (int k = 0; k < K1; k++)
                if (k == j1) sel1_nxt[k] = digits[0];
            cnt1_nxt = 2'(j1 + 1);
        end

        p2 = 0;
        for (int i = 0; i < K2; i++)
            if (i < int'(cnt2) && sel2[i] >= digits[0]) p2 = i + 1;
        j2 = (K2 - rem > p2) ? K2 - rem : p2;
        if (j2 < K2) begin
            for (int k = 0; k < K2; k++)
                if (k == j2) sel2_nxt[k] = digits[0];
            cnt2_nxt = 4'(j2 + 1);
        end
    end

    always_comb begin
        part1 = 16'(sel1[0]) * 16'd10 + 16'(sel1[1]);
        part2 = '0;
        for (int k = 0; k < K2; k++)
            part2 = part2 * 40'd10 + 40'(sel2[k]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            joltage1_out <= '0;
            joltage2_out <= '0;
            done         <= 1'b0;
            idx          <= '0;
            cnt1         <= '0;
            cnt2         <= '0;
            // NOTE: the digit and selection arrays are cleared here, so reset costs a clear path per entry.
            sel1         <= '{default: '0};
            sel2         <= '{default: '0};
            digits       <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && data_valid) begin
                        digits <= line;
                        sel1   <= '{default: '0};
                        sel2   <= '{default: '0};
                        cnt1   <= '0;
                        cnt2   <= '0;
                        idx    <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    sel1 <= sel1_nxt;
                    cnt1 <= cnt1_nxt;
                    sel2 <= sel2_nxt;
                    cnt2 <= cnt2_nxt;
                    for (int i = 0; i < LENGTH - 1; i++)
                        digits[i] <= digits[i+1];
                    digits[LENGTH-1] <= '0;
                    if (idx == IW'(LENGTH - 1)) begin
                        state <= ACC;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ACC: begin
                    joltage1_out <= joltage1_out + part1;
                    joltage2_out <= joltage2_out + 64'(part2);
                    done         <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joltage.sv
// Self-checking bench for joltage: directed table, random lines against a greedy
// window-maximum model, reset abort, back-to-back streaming and sum wrap.
module tb_joltage;

    localparam int L_S = 15;
    localparam int L_B = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start_s = 1'b0, dv_s = 1'b0;
    logic [3:0]  line_s [0:L_S-1];
    logic [15:0] j1_s;
    logic [63:0] j2_s;
    logic        done_s;

    logic        start_b = 1'b0, dv_b = 1'b0;
    logic [3:0]  line_b [0:L_B-1];
    logic [15:0] j1_b;
    logic [63:0] j2_b;
    logic        done_b;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp1;
    logic [63:0] exp2;

    always #5 clk = ~clk;

    joltage #(.LENGTH(L_S)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .data_valid(dv_s), .line(line_s),
        .joltage1_out(j1_s), .joltage2_out(j2_s), .done(done_s)
    );

    joltage #(.LENGTH(L_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data_valid(dv_b), .line(line_b),
        .joltage1_out(j1_b), .joltage2_out(j2_b), .done(done_b)
    );

    typedef struct {
        logic [59:0]     digs;   // one decimal digit per nibble, leftmost first
        int unsigned     p1;
        longint unsigned p2;
    } vec_t;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: for each of the K output positions pick the largest digit in the
    // window that still leaves enough digits after it; first occurrence wins ties.
    function automatic longint unsigned best_k(input int d[$], input int k);
        longint unsigned v = 0;
        int from = 0;
        for (int n = 0; n < k; n++) begin
            int bi = from;
            for (int i = from; i <= d.size() - k + n; i++)
                if (d[i] > d[bi]) bi = i;
            v = v * 64'd10 + 64'(d[bi]);
            from = bi + 1;
        end
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp1 = '0;
        exp2 = '0;
    endtask

    // Captures v on the next edge, scrambles line during the scan, returns edges until done.
    task automatic feed_s(input logic [59:0] v, output int lat);
        for (int i = 0; i < L_S; i++) line_s[i] = v[59 - 4*i -: 4];
        start_s = 1'b1; dv_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0; dv_s = 1'b0;
        for (int i = 0; i < L_S; i++) line_s[i] = 4'($urandom_range(0, 9));
        lat = -1;
        for (int e = 1; e <= L_S + 20; e++) begin
            @(posedge clk); #1;
            if (done_s) begin lat = e; break; end
        end
    endtask

    task automatic feed_b(input int d[$], output int lat);
        for (int i = 0; i < L_B; i++) line_b[i] = 4'(d[i]);
        start_b = 1'b1; dv_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; dv_b = 1'b0;
        lat = -1;
        for (int e = 1; e <= L_B + 20; e++) begin
            @(posedge clk); #1;
            if (done_b) begin lat = e; break; end
        end
    endtask

    initial begin
        vec_t tab [6];
        int   lat;
        int   cnt;
        int   first_e;
        int   second_e;
        int   q[$];

        tab[0] = '{60'h987654321111111, 98, 64'd987654321111};
        tab[1] = '{60'h811111111111119, 89, 64'd811111111119};
        tab[2] = '{60'h234234234234278, 78, 64'd434234234278};
        tab[3] = '{60'h818181911112111, 92, 64'd888911112111};
        tab[4] = '{60'h999999999999999, 99, 64'd999999999999};
        tab[5] = '{60'h000000000000000, 0,  64'd0};

        for (int i = 0; i < L_S; i++) line_s[i] = '0;
        for (int i = 0; i < L_B; i++) line_b[i] = '0;

        // Reset state and idle behaviour with data_valid low.
        do_reset();
        check("reset_j1", j1_s, 0);
        check("reset_j2", j2_s, 0);
        check("reset_done", done_s, 0);
        start_s = 1'b1; dv_s = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done_s) cnt++;
        end
        start_s = 1'b0;
        check("idle_no_done", cnt, 0);
        check("idle_j1", j1_s, 0);
        check("idle_j2", j2_s, 0);

        // Directed table: latency, pulse width, per-line accumulation.
        for (int t = 0; t < 6; t++) begin
            feed_s(tab[t].digs, lat);
            exp1 = exp1 + 16'(tab[t].p1);
            exp2 = exp2 + tab[t].p2;
            check($sformatf("tab%0d_latency", t), longint'(lat), L_S + 1);
            check($sformatf("tab%0d_j1", t), j1_s, exp1);
            check($sformatf("tab%0d_j2", t), j2_s, exp2);
            @(posedge clk); #1;
            check($sformatf("tab%0d_done_width", t), done_s, 0);
            if (t == 3) begin
                check("four_lines_j1", j1_s, 357);
                check("four_lines_j2", j2_s, 64'd3121910778619);
            end
        end

        // Reset during the scan aborts the line without accumulating.
        do_reset();
        for (int i = 0; i < L_S; i++) line_s[i] = 4'd9;
        start_s = 1'b1; dv_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0; dv_s = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (L_S + 10) begin
            @(posedge clk); #1;
            if (done_s) cnt++;
        end
        check("abort_no_done", cnt, 0);
        check("abort_j1", j1_s, 0);
        check("abort_j2", j2_s, 0);
        feed_s(60'h987654321111111, lat);
        check("after_abort_latency", longint'(lat), L_S + 1);
        check("after_abort_j1", j1_s, 98);
        check("after_abort_j2", j2_s, 64'd987654321111);
        @(posedge clk); #1;
        exp1 = 16'd98;
        exp2 = 64'd987654321111;

        // Random lines on the short instance, some with a narrow digit range for ties.
        for (int n = 0; n < 20; n++) begin
            logic [59:0] v;
            int maxd;
            maxd = int'($urandom_range(1, 9));
            q = {};
            for (int i = 0; i < L_S; i++) q.push_back(int'($urandom_range(0, maxd)));
            for (int i = 0; i < L_S; i++) v[59 - 4*i -: 4] = 4'(q[i]);
            feed_s(v, lat);
            exp1 = exp1 + 16'(best_k(q, 2));
            exp2 = exp2 + best_k(q, 12);
            check($sformatf("rnd%0d_latency", n), longint'(lat), L_S + 1);
            check($sformatf("rnd%0d_j1", n), j1_s, exp1);
            check($sformatf("rnd%0d_j2", n), j2_s, exp2);
            @(posedge clk); #1;
        end

        // Random lines on the full-length instance.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            q = {};
            for (int i = 0; i < L_B; i++) q.push_back(int'($urandom_range(0, 9)));
            feed_b(q, lat);
            exp1 = exp1 + 16'(best_k(q, 2));
            exp2 = exp2 + best_k(q, 12);
            check($sformatf("big%0d_latency", n), longint'(lat), L_B + 1);
            check($sformatf("big%0d_j1", n), j1_b, exp1);
            check($sformatf("big%0d_j2", n), j2_b, exp2);
            @(posedge clk); #1;
        end

        // 700 lines of all 9s with start/data_valid held high: period and wrap.
        do_reset();
        for (int i = 0; i < L_B; i++) line_b[i] = 4'd9;
        start_b = 1'b1; dv_b = 1'b1;
        cnt = 0; first_e = -1; second_e = -1;
        for (int e = 0; e < 700 * (L_B + 3) + 200; e++) begin
            @(posedge clk); #1;
            if (done_b) begin
                cnt++;
                if (cnt == 1) first_e = e;
                if (cnt == 2) second_e = e;
                if (cnt == 700) begin
                    start_b = 1'b0; dv_b = 1'b0;
                    break;
                end
            end
        end
        start_b = 1'b0; dv_b = 1'b0;
        check("wrap_done_count", cnt, 700);
        check("stream_period", longint'(second_e - first_e), L_B + 3);
        check("wrap_j1", j1_b, 16'((700 * 99) % 65536));
        check("wrap_j2", j2_b, 64'd700 * 64'd999999999999);
        repeat (L_B + 10) @(posedge clk);
        #1;
        check("wrap_hold_j1", j1_b, 3764);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
